// File: rtl/fft8_pkg.sv
// Shared types, constants and descriptor math for the 8-point radix-2 DIT butterfly sequencer.
package fft8_pkg;

    localparam int N            = 8;
    localparam int LOG2N        = 3;
    localparam int BF_PER_STAGE = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] k;
    } bf_desc_t;

    // tw_bus is packed {W3_im,W3_re,...,W0_im,W0_re}, lowest field first
    function automatic int tw_re_lsb(input int k, input int tw_w);
        return 2 * k * tw_w;
    endfunction

    function automatic int tw_im_lsb(input int k, input int tw_w);
        return (2 * k + 1) * tw_w;
    endfunction

    function automatic bf_desc_t bf_desc(input logic [1:0] s, input logic [1:0] j);
        bf_desc_t   d;
        logic [2:0] jj;
        logic [2:0] h;
        logic [2:0] jm;
        jj  = {1'b0, j};
        h   = 3'd1 << s;
        jm  = jj & (h - 3'd1);
        d.a = ((jj >> s) << (s + 2'd1)) + jm;
        d.b = d.a + h;
        d.k = 2'(jm << (2'd2 - s));
        return d;
    endfunction

endpackage

// File: rtl/fft8_butterfly_sequencer_if.sv
// Descriptor/ack channel between the sequencer (master) and the butterfly unit (slave).
interface fft8_butterfly_sequencer_if #(
    parameter int TW_W = 16
);
    logic            valid;
    logic            ready;
    logic [1:0]      stage;
    logic [2:0]      idx_a;
    logic [2:0]      idx_b;
    logic [TW_W-1:0] tw_re;
    logic [TW_W-1:0] tw_im;
    logic            ack;

    modport master (
        output valid, stage, idx_a, idx_b, tw_re, tw_im,
        input  ready, ack
    );

    modport slave (
        input  valid, stage, idx_a, idx_b, tw_re, tw_im,
        output ready, ack
    );
endinterface

// File: rtl/fft8_bf_addr_gen.sv
// Combinational (stage, butterfly) -> (operand a, operand b, twiddle index k).
module fft8_bf_addr_gen
    import fft8_pkg::*;
(
    input  logic [1:0] i_stage,
    input  logic [1:0] i_j,
    output logic [2:0] o_idx_a,
    output logic [2:0] o_idx_b,
    output logic [1:0] o_k
);

    bf_desc_t w_desc;

    assign w_desc  = bf_desc(i_stage, i_j);
    assign o_idx_a = w_desc.a;
    assign o_idx_b = w_desc.b;
    assign o_k     = w_desc.k;

endmodule

// File: rtl/fft8_butterfly_sequencer.sv
// Walks the 3 DIT stages x 4 butterflies, issuing index/twiddle descriptors with a per-stage ack barrier.
module fft8_butterfly_sequencer
    import fft8_pkg::*;
#(
    parameter int TW_W    = 16,
    parameter int ACK_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_fftorifft,
    output logic                        o_rom_mode,
    input  logic [8*TW_W-1:0]           i_tw_bus,
    fft8_butterfly_sequencer_if.master  bf,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_ack_err
);

    localparam logic [2:0] J_END      = 3'(BF_PER_STAGE);
    localparam logic [2:0] ACK_END    = 3'(ACK_MAX);
    localparam logic [1:0] LAST_STAGE = 2'(LOG2N - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_stage;
    logic [2:0]      r_j;
    logic [2:0]      r_ack_cnt;
    logic            r_valid;
    logic [1:0]      r_bf_stage;
    logic [2:0]      r_idx_a;
    logic [2:0]      r_idx_b;
    logic [TW_W-1:0] r_tw_re;
    logic [TW_W-1:0] r_tw_im;
    logic            r_rom_mode;
    logic            r_busy;
    logic            r_ack_err;

    logic            w_fire;
    logic            w_load;
    logic            w_drop;
    logic            w_start_ok;
    logic            w_stage_adv;
    logic            w_ack_ok;
    logic            w_ack_bad;
    logic [2:0]      w_idx_a;
    logic [2:0]      w_idx_b;
    logic [1:0]      w_k;
    logic [TW_W-1:0] w_tw_re [BF_PER_STAGE];
    logic [TW_W-1:0] w_tw_im [BF_PER_STAGE];

    generate
        for (genvar gi = 0; gi < BF_PER_STAGE; gi++) begin : g_tw
            assign w_tw_re[gi] = i_tw_bus[tw_re_lsb(gi, TW_W) +: TW_W];
            assign w_tw_im[gi] = i_tw_bus[tw_im_lsb(gi, TW_W) +: TW_W];
        end
    endgenerate

    fft8_bf_addr_gen u_addr_gen (
        .i_stage (r_stage),
        .i_j     (r_j[1:0]),
        .o_idx_a (w_idx_a),
        .o_idx_b (w_idx_b),
        .o_k     (w_k)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_ISSUE;
            ST_ISSUE: if (w_drop)  w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (r_ack_cnt == ACK_END) begin
                    w_state_next = (r_stage == LAST_STAGE) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_fire      = !r_valid || bf.ready;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_start_ok  = 1'b0;
        w_stage_adv = 1'b0;
        w_ack_ok    = 1'b0;
        w_ack_bad   = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start_ok = i_start;
                w_ack_bad  = bf.ack;
            end
            ST_ISSUE: begin
                w_load    = w_fire && (r_j != J_END);
                w_drop    = w_fire && (r_j == J_END);
                w_ack_ok  = bf.ack && (r_ack_cnt != ACK_END);
                w_ack_bad = bf.ack && (r_ack_cnt == ACK_END);
            end
            ST_DRAIN: begin
                w_stage_adv = (r_ack_cnt == ACK_END) && (r_stage != LAST_STAGE);
                w_ack_ok    = bf.ack && (r_ack_cnt != ACK_END);
                w_ack_bad   = bf.ack && (r_ack_cnt == ACK_END);
            end
            ST_DONE: begin
                o_done    = 1'b1;
                w_ack_bad = bf.ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage    <= '0;
            r_j        <= '0;
            r_ack_cnt  <= '0;
            r_valid    <= 1'b0;
            r_bf_stage <= '0;
            r_idx_a    <= '0;
            r_idx_b    <= '0;
            r_tw_re    <= '0;
            r_tw_im    <= '0;
            r_rom_mode <= 1'b0;
            r_busy     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_rom_mode <= i_fftorifft;
                r_stage    <= '0;
                r_j        <= '0;
                r_ack_cnt  <= '0;
                r_busy     <= 1'b1;
            end
            // Twiddle is captured alongside the indices so a stalled descriptor stays coherent
            if (w_load) begin
                r_valid    <= 1'b1;
                r_bf_stage <= r_stage;
                r_idx_a    <= w_idx_a;
                r_idx_b    <= w_idx_b;
                r_tw_re    <= w_tw_re[w_k];
                r_tw_im    <= w_tw_im[w_k];
                r_j        <= r_j + 3'd1;
            end
            if (w_drop) begin
                r_valid <= 1'b0;
            end
            if (w_stage_adv) begin
                r_stage   <= r_stage + 2'd1;
                r_j       <= '0;
                r_ack_cnt <= '0;
            end else if (w_ack_ok) begin
                r_ack_cnt <= r_ack_cnt + 3'd1;
            end
            if (w_ack_bad) begin
                r_ack_err <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign bf.valid   = r_valid;
    assign bf.stage   = r_bf_stage;
    assign bf.idx_a   = r_idx_a;
    assign bf.idx_b   = r_idx_b;
    assign bf.tw_re   = r_tw_re;
    assign bf.tw_im   = r_tw_im;
    assign o_rom_mode = r_rom_mode;
    assign o_busy     = r_busy;
    assign o_ack_err  = r_ack_err;

endmodule

// File: tb/tb_fft8_butterfly_sequencer.sv
// Scoreboard bench: expected descriptors queued at start, monitor pops and compares on every handshake.
module tb_fft8_butterfly_sequencer;

    localparam int TW_W = 16;
    localparam logic [8*TW_W-1:0] FFT_BUS  = {16'hB9A8, 16'hB9A8, 16'hBC00, 16'h0000,
                                              16'hB9A8, 16'h39A8, 16'h0000, 16'h3C00};
    localparam logic [8*TW_W-1:0] IFFT_BUS = {16'h39A8, 16'hB9A8, 16'h3C00, 16'h0000,
                                              16'h39A8, 16'h39A8, 16'h0000, 16'h3C00};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              fftorifft = 1'b0;
    logic              rom_mode;
    logic              busy;
    logic              done;
    logic              ack_err;
    logic [8*TW_W-1:0] tw_bus;

    fft8_butterfly_sequencer_if #(.TW_W(TW_W)) bf_if ();

    fft8_butterfly_sequencer #(.TW_W(TW_W), .ACK_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_fftorifft (fftorifft),
        .o_rom_mode  (rom_mode),
        .i_tw_bus    (tw_bus),
        .bf          (bf_if),
        .o_busy      (busy),
        .o_done      (done),
        .o_ack_err   (ack_err)
    );

    // ROM model: combinational twiddle set selected by the latched mode
    assign tw_bus = rom_mode ? IFFT_BUS : FFT_BUS;

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          hs_count = 0;
    int          cycle = 0;
    logic [40:0] exp_q [$];
    int          ack_q [$];
    bit          hs_pend = 1'b0;
    bit          hold_acks = 1'b0;
    bit          extra_ack = 1'b0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [40:0] prev_desc = '0;

    int          a_tab   [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int          b_tab   [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int          k_tab   [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    logic [15:0] re_tab  [4]  = '{16'h3C00, 16'h39A8, 16'h0000, 16'hB9A8};
    logic [15:0] fim_tab [4]  = '{16'h0000, 16'hB9A8, 16'hBC00, 16'hB9A8};
    logic [15:0] iim_tab [4]  = '{16'h0000, 16'h39A8, 16'h3C00, 16'h39A8};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [40:0] exp_desc(input logic mode, input int i);
        int k;
        k = k_tab[i];
        return {1'b1, 2'(i / 4), 3'(a_tab[i]), 3'(b_tab[i]), re_tab[k],
                mode ? iim_tab[k] : fim_tab[k]};
    endfunction

    function automatic logic [40:0] cur_desc();
        return {bf_if.valid, bf_if.stage, bf_if.idx_a, bf_if.idx_b, bf_if.tw_re, bf_if.tw_im};
    endfunction

    function automatic logic [44:0] outs_vec();
        return {rom_mode, busy, done, ack_err, cur_desc()};
    endfunction

    // Monitor: handshake happens at the posedge following a negedge that sees valid & ready
    always @(negedge clk) begin
        logic [40:0] cur;
        logic [40:0] exp;
        if (rst) begin
            hs_pend    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cur = cur_desc();
            if (prev_stall) check("stall_hold", 64'(cur), 64'(prev_desc));
            hs_pend = bf_if.valid && bf_if.ready;
            if (hs_pend) begin
                hs_count++;
                $display("desc s=%0d a=%0d b=%0d tw=%h/%h", bf_if.stage, bf_if.idx_a,
                         bf_if.idx_b, bf_if.tw_re, bf_if.tw_im);
                if (exp_q.size() == 0) begin
                    check("extra_desc", 64'(cur), 64'(0));
                end else begin
                    exp = exp_q.pop_front();
                    check("desc", 64'(cur), 64'(exp));
                end
            end
            prev_stall = bf_if.valid && !bf_if.ready;
            prev_desc  = cur;
        end
    end

    // Responder: ready pattern and one ack per handshake, 3 cycles later
    initial begin
        int  popped;
        bit  due;
        bf_if.ready = 1'b1;
        bf_if.ack   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (rst) begin
                ack_q.delete();
                bf_if.ack = 1'b0;
            end else begin
                if (hs_pend) ack_q.push_back(cycle + 2);
                due = !hold_acks && (ack_q.size() > 0) && (ack_q[0] <= cycle);
                if (due) popped = ack_q.pop_front();
                bf_if.ack   = due || extra_ack;
                bf_if.ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    task automatic kick(input logic mode);
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_desc(mode, i));
        fftorifft = mode;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input logic mode);
        int n = 0;
        while (!done && n < 800) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'(1));
        check("done_mode_busy", 64'({rom_mode, busy}), 64'({mode, 1'b1}));
        check("all_issued", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        check("done_pulse_busy_fall", 64'({done, busy}), 64'(0));
    endtask

    task automatic wait_s1();
        int n = 0;
        while (!(bf_if.valid && bf_if.stage == 2'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_s1", 64'({bf_if.valid, bf_if.stage}), 64'({1'b1, 2'd1}));
    endtask

    initial begin
        bit seen;
        bit ok;
        int base;
        int n;

        repeat (2) @(negedge clk);
        check("reset_outs", 64'(outs_vec()), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        $display("run 1: FFT, ready high");
        kick(1'b0);
        check("latency_busy_novalid", 64'({busy, bf_if.valid}), 64'(2'b10));
        @(negedge clk);
        check("latency_first_valid", 64'(bf_if.valid), 64'(1));
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ok &= bf_if.valid;
        end
        check("no_bubble", 64'(ok), 64'(1));
        wait_done(1'b0);
        check("no_ack_err_1", 64'(ack_err), 64'(0));

        $display("run 2: IFFT, ready high");
        kick(1'b1);
        wait_done(1'b1);

        $display("run 3: FFT, ready random");
        rand_ready = 1'b1;
        kick(1'b0);
        wait_done(1'b0);
        rand_ready = 1'b0;
        check("no_ack_err_3", 64'(ack_err), 64'(0));

        $display("run 4: acks withheld in stage 0");
        hold_acks = 1'b1;
        base = hs_count;
        kick(1'b0);
        n = 0;
        while (hs_count < base + 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= bf_if.valid;
        end
        check("barrier_hold", 64'(seen), 64'(0));
        hold_acks = 1'b0;
        n = 0;
        while (!bf_if.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("barrier_release", 64'({bf_if.valid, bf_if.stage}), 64'({1'b1, 2'd1}));
        wait_done(1'b0);

        $display("run 5: start while busy, then stray ack");
        kick(1'b0);
        wait_s1();
        fftorifft = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        fftorifft = 1'b0;
        check("start_ignored", 64'({rom_mode, busy}), 64'(2'b01));
        wait_done(1'b0);
        check("ack_err_clear", 64'(ack_err), 64'(0));
        extra_ack = 1'b1;
        @(negedge clk);
        extra_ack = 1'b0;
        @(negedge clk);
        check("ack_err_set", 64'(ack_err), 64'(1));
        repeat (5) @(negedge clk);
        check("ack_err_sticky", 64'(ack_err), 64'(1));

        $display("run 6: reset mid stage 1");
        kick(1'b0);
        wait_s1();
        rst = 1'b1;
        #1;
        check("reset_immediate", 64'(outs_vec()), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        kick(1'b0);
        wait_done(1'b0);
        check("clean_after_reset", 64'(ack_err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
